tl_grant_finish_unit: RTL

- Client-side consumer of the TileLink grant channel.
- Sits between the client ports of the TileLink enqueuer stage and the client cache or refill logic.
- Forwards grant beats unchanged to the client.
- Tracks multi-beat data grants and, on the last beat of any grant that requires acknowledgement, queues a finish message back toward the manager through the enqueuer's client finish port.

---
 rtl/tl_grant_finish_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tl_grant_finish_unit.sv
// TileLink client grant consumer: forwards grant beats unchanged and queues finish messages for grants that need them.
// Optional sticky beat-order checker is enabled with `define TL_FINISH_BEAT_CHECK_EN.
module tl_grant_finish_unit #(
  parameter int FQ_DEPTH   = 2,
  parameter int DATA_BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_in_grant_ready,
  input  logic        io_in_grant_valid,
  input  logic [1:0]  io_in_grant_bits_header_src,
  input  logic [1:0]  io_in_grant_bits_header_dst,
  input  logic [2:0]  io_in_grant_bits_payload_addr_beat,
  input  logic        io_in_grant_bits_payload_client_xact_id,
  input  logic [1:0]  io_in_grant_bits_payload_manager_xact_id,
  input  logic        io_in_grant_bits_payload_is_builtin_type,
  input  logic [3:0]  io_in_grant_bits_payload_g_type,
  input  logic [63:0] io_in_grant_bits_payload_data,
  input  logic        io_out_grant_ready,
  output logic        io_out_grant_valid,
  output logic [1:0]  io_out_grant_bits_header_src,
  output logic [1:0]  io_out_grant_bits_header_dst,
  output logic [2:0]  io_out_grant_bits_payload_addr_beat,
  output logic        io_out_grant_bits_payload_client_xact_id,
  output logic [1:0]  io_out_grant_bits_payload_manager_xact_id,
  output logic        io_out_grant_bits_payload_is_builtin_type,
  output logic [3:0]  io_out_grant_bits_payload_g_type,
  output logic [63:0] io_out_grant_bits_payload_data,
  input  logic        io_finish_ready,
  output logic        io_finish_valid,
  output logic [1:0]  io_finish_bits_header_src,
  output logic [1:0]  io_finish_bits_header_dst,
  output logic [1:0]  io_finish_bits_payload_manager_xact_id,
  output logic        io_beat_error
);

  localparam int              PW        = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [2:0]      LAST_BEAT = 3'(DATA_BEATS - 1);
  localparam logic [2:0]      FQ_FULL   = 3'(FQ_DEPTH);
  localparam logic [PW-1:0]   PTR_LAST  = PW'(FQ_DEPTH - 1);

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [1:0] xact;
  } fin_t;

  logic [2:0]    r_beat_cnt;
  logic [2:0]    r_fq_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  fin_t          r_fq_mem [FQ_DEPTH];

  logic w_multibeat, w_needs_finish, w_last, w_stall, w_accept, w_push, w_pop;
  fin_t w_fin_in;
  fin_t w_fin_head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_multibeat    = io_in_grant_bits_payload_is_builtin_type
                          ? (io_in_grant_bits_payload_g_type == 4'd4)
                          : (io_in_grant_bits_payload_g_type <= 4'd1);
  assign w_needs_finish = !io_in_grant_bits_payload_is_builtin_type;
  assign w_last         = !w_multibeat || (r_beat_cnt == LAST_BEAT);

  // Stall looks only at the registered count, so a same-cycle pop never unblocks a full queue.
  assign w_stall  = w_needs_finish && w_last && (r_fq_count == FQ_FULL);
  assign w_accept = io_in_grant_valid && io_in_grant_ready;
  assign w_push   = w_accept && w_needs_finish && w_last;
  assign w_pop    = io_finish_valid && io_finish_ready;

  assign io_in_grant_ready  = io_out_grant_ready && !w_stall;
  assign io_out_grant_valid = io_in_grant_valid && !w_stall;

  assign io_out_grant_bits_header_src              = io_in_grant_bits_header_src;
  assign io_out_grant_bits_header_dst              = io_in_grant_bits_header_dst;
  assign io_out_grant_bits_payload_addr_beat       = io_in_grant_bits_payload_addr_beat;
  assign io_out_grant_bits_payload_client_xact_id  = io_in_grant_bits_payload_client_xact_id;
  assign io_out_grant_bits_payload_manager_xact_id = io_in_grant_bits_payload_manager_xact_id;
  assign io_out_grant_bits_payload_is_builtin_type = io_in_grant_bits_payload_is_builtin_type;
  assign io_out_grant_bits_payload_g_type          = io_in_grant_bits_payload_g_type;
  assign io_out_grant_bits_payload_data            = io_in_grant_bits_payload_data;

  // A finish travels back toward the grant's sender, so src/dst swap.
  assign w_fin_in = '{src:  io_in_grant_bits_header_dst,
                      dst:  io_in_grant_bits_header_src,
                      xact: io_in_grant_bits_payload_manager_xact_id};

  assign w_fin_head                             = r_fq_mem[r_rd_ptr];
  assign io_finish_valid                        = (r_fq_count != 3'd0);
  assign io_finish_bits_header_src              = w_fin_head.src;
  assign io_finish_bits_header_dst              = w_fin_head.dst;
  assign io_finish_bits_payload_manager_xact_id = w_fin_head.xact;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= 3'd0;
      r_fq_count <= 3'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_accept && w_multibeat)
        r_beat_cnt <= w_last ? 3'd0 : r_beat_cnt + 3'd1;
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_fq_count <= r_fq_count + 3'd1;
        2'b01:   r_fq_count <= r_fq_count - 3'd1;
        default: r_fq_count <= r_fq_count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fq_mem[r_wr_ptr] <= w_fin_in;
  end

`ifdef TL_FINISH_BEAT_CHECK_EN
  logic r_beat_error;

  always_ff @(posedge clk) begin
    if (reset)
      r_beat_error <= 1'b0;
    else if (w_accept && w_multibeat && (io_in_grant_bits_payload_addr_beat != r_beat_cnt))
      r_beat_error <= 1'b1;
  end

  assign io_beat_error = r_beat_error;
`else
  assign io_beat_error = 1'b0;
`endif

endmodule
